// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit counter to exist.
  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the caller can form signed overflow on the final chunk.
module chunk_adder #(
  parameter int CHUNK = 3
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] w_cvec;
  logic             w_c;

  // Bit-serial ripple: w_cvec[i] records the carry entering bit i.
  always_comb begin
    w_c    = ci;
    w_cvec = {CHUNK{1'b0}};
    s      = {CHUNK{1'b0}};
    for (int i = 0; i < CHUNK; i++) begin
      w_cvec[i] = w_c;
      s[i]      = a[i] ^ b[i] ^ w_c;
      w_c       = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
  end

  assign co       = w_c;
  assign c_msb_in = w_cvec[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered ripple
// carry, valid/ready on both sides.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH must be >= 2 and an exact multiple of CHUNK >= 1");
  end

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  int               w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_co;
  logic             w_msb_in;
  logic             w_last;
  logic             w_accept;

  assign w_base    = int'(r_cnt) * CHUNK;
  assign w_a_chunk = r_a[w_base +: CHUNK];
  assign w_b_chunk = r_b[w_base +: CHUNK];
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_accept  = (r_state == ST_IDLE) && in_valid;

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .a       (w_a_chunk),
    .b       (w_b_chunk),
    .ci      (r_carry),
    .s       (w_sum),
    .co      (w_co),
    .c_msb_in(w_msb_in)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_BUSY; else w_next = ST_IDLE;
      ST_BUSY: if (w_last)    w_next = ST_DONE; else w_next = ST_BUSY;
      ST_DONE: if (out_ready) w_next = ST_IDLE; else w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture and per-chunk accumulation; subtraction is a + ~b + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_s     <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (r_state == ST_BUSY) begin
      r_s[w_base +: CHUNK] <= w_sum;
      r_carry              <= w_co;
      r_cnt                <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= w_msb_in ^ w_co;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and random checks of seq_chunk_adder in four width/chunk configurations
// sharing one operand bus, each with its own in_valid.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] a_i = 12'h000;
  logic [11:0] b_i = 12'h000;
  logic        cin_i = 1'b0;
  logic        sub_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [3:0]  in_valid_i = 4'h0;
  logic [3:0]  in_ready_o;
  logic [3:0]  out_valid_o;
  logic [3:0]  cout_o;
  logic [3:0]  ovf_o;
  logic [11:0] s0;
  logic [2:0]  s1;
  logic [7:0]  s2;
  logic [7:0]  s3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(12), .CHUNK(3)) u_w12c3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_i[0]), .in_ready(in_ready_o[0]),
    .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i), .out_valid(out_valid_o[0]),
    .out_ready(out_ready_i), .s(s0), .cout(cout_o[0]), .ovf(ovf_o[0]));

  seq_chunk_adder #(.WIDTH(3), .CHUNK(3)) u_w3c3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_i[1]), .in_ready(in_ready_o[1]),
    .a(a_i[2:0]), .b(b_i[2:0]), .cin(cin_i), .sub(sub_i), .out_valid(out_valid_o[1]),
    .out_ready(out_ready_i), .s(s1), .cout(cout_o[1]), .ovf(ovf_o[1]));

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_i[2]), .in_ready(in_ready_o[2]),
    .a(a_i[7:0]), .b(b_i[7:0]), .cin(cin_i), .sub(sub_i), .out_valid(out_valid_o[2]),
    .out_ready(out_ready_i), .s(s2), .cout(cout_o[2]), .ovf(ovf_o[2]));

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_i[3]), .in_ready(in_ready_o[3]),
    .a(a_i[7:0]), .b(b_i[7:0]), .cin(cin_i), .sub(sub_i), .out_valid(out_valid_o[3]),
    .out_ready(out_ready_i), .s(s3), .cout(cout_o[3]), .ovf(ovf_o[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [11:0] get_s(input int sel);
    case (sel)
      0:       return s0;
      1:       return {9'd0, s1};
      2:       return {4'd0, s2};
      default: return {4'd0, s3};
    endcase
  endfunction

  function automatic int width_of(input int sel);
    case (sel)
      0:       return 12;
      1:       return 3;
      default: return 8;
    endcase
  endfunction

  function automatic int lat_of(input int sel);
    case (sel)
      0:       return 4;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  // Full-width reference, independent of chunking.
  task automatic ref_model(input int w, input logic [11:0] a, input logic [11:0] b,
                           input logic cin, input logic sub,
                           output logic [11:0] rs, output logic rc, output logic ro);
    int mask, ia, ib, full;
    mask = (1 << w) - 1;
    ia   = int'(a) & mask;
    ib   = sub ? (~int'(b)) & mask : int'(b) & mask;
    full = ia + ib + (sub ? 1 : int'(cin));
    rs   = 12'(full & mask);
    rc   = ((full >> w) & 1) != 0;
    ro   = ((((ia >> (w - 1)) & 1) == ((ib >> (w - 1)) & 1)) &&
            (((full >> (w - 1)) & 1) != ((ia >> (w - 1)) & 1)));
  endtask

  task automatic run_op(input int sel, input logic [11:0] a, input logic [11:0] b,
                        input logic cin, input logic sub, input int stall, input bit inject,
                        input logic [11:0] es, input logic ec, input logic eo, input string tag);
    int lat;
    @(negedge clk);
    a_i = a; b_i = b; cin_i = cin; sub_i = sub;
    in_valid_i[sel] = 1'b1;
    chk({tag, " in_ready"}, 32'(in_ready_o[sel]), 32'd1);
    @(posedge clk); #1;
    in_valid_i = 4'h0;
    cin_i = ~cin;
    lat = 0;
    while (!out_valid_o[sel] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(lat_of(sel)));
    chk({tag, " s"}, 32'(get_s(sel)), 32'(es));
    chk({tag, " cout"}, 32'(cout_o[sel]), 32'(ec));
    chk({tag, " ovf"}, 32'(ovf_o[sel]), 32'(eo));
    for (int k = 0; k < stall; k++) begin
      if (inject) begin
        a_i = ~a; b_i = a; sub_i = ~sub;
        in_valid_i[sel] = 1'b1;
      end
      @(posedge clk); #1;
      chk({tag, " hold"},
          {16'd0, out_valid_o[sel], in_ready_o[sel], cout_o[sel], ovf_o[sel], get_s(sel)},
          {16'd0, 1'b1, 1'b0, ec, eo, es});
    end
    in_valid_i = 4'h0;
    @(negedge clk);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    chk({tag, " release"}, {30'd0, out_valid_o[sel], in_ready_o[sel]}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [11:0] ra, rb, rs;
    logic        rcin, rsub, rc, ro;
    int          sel, w;

    #12;
    chk("reset in_ready", 32'(in_ready_o), 32'hF);
    chk("reset out_valid", 32'(out_valid_o), 32'h0);
    chk("reset outputs", {15'd0, cout_o[0], ovf_o[0], 3'd0, s0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3-bit single-chunk additions
    run_op(1, 12'd6, 12'd1, 1'b0, 1'b0, 0, 1'b0, 12'd7, 1'b0, 1'b0, "w3 6+1");
    run_op(1, 12'd2, 12'd3, 1'b0, 1'b0, 0, 1'b0, 12'd5, 1'b0, 1'b1, "w3 2+3");
    run_op(1, 12'd5, 12'd4, 1'b0, 1'b0, 0, 1'b0, 12'd1, 1'b1, 1'b1, "w3 5+4");

    // 12-bit additions and subtractions
    run_op(0, 12'hFFF, 12'h001, 1'b0, 1'b0, 0, 1'b0, 12'h000, 1'b1, 1'b0, "w12 fff+1");
    run_op(0, 12'h7FF, 12'h001, 1'b0, 1'b0, 0, 1'b0, 12'h800, 1'b0, 1'b1, "w12 7ff+1");
    run_op(0, 12'h0FF, 12'h000, 1'b1, 1'b0, 0, 1'b0, 12'h100, 1'b0, 1'b0, "w12 ff+0+c");
    run_op(0, 12'h005, 12'h007, 1'b1, 1'b1, 0, 1'b0, 12'hFFE, 1'b0, 1'b0, "w12 5-7");
    run_op(0, 12'h800, 12'h001, 1'b0, 1'b1, 0, 1'b0, 12'h7FF, 1'b1, 1'b1, "w12 800-1");

    // Backpressure with ignored new operands, then a follow-up transaction
    run_op(0, 12'h3A5, 12'h0F0, 1'b0, 1'b0, 5, 1'b1, 12'h495, 1'b0, 1'b0, "bp hold");
    run_op(0, 12'h800, 12'h800, 1'b0, 1'b0, 0, 1'b0, 12'h000, 1'b1, 1'b1, "bp next");

    // Asynchronous reset two chunks into an operation
    @(negedge clk);
    a_i = 12'hFFF; b_i = 12'hFFF; cin_i = 1'b0; sub_i = 1'b0;
    in_valid_i[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 4'h0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset state", {30'd0, out_valid_o[0], in_ready_o[0]}, {30'd0, 1'b0, 1'b1});
    chk("midreset outputs", {18'd0, cout_o[0], ovf_o[0], s0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 12'h123, 12'h456, 1'b0, 1'b0, 0, 1'b0, 12'h579, 1'b0, 1'b0, "post reset");

    // Random operands across the three larger configurations
    for (int i = 0; i < 1000; i++) begin
      case (i % 3)
        0:       sel = 0;
        1:       sel = 2;
        default: sel = 3;
      endcase
      w    = width_of(sel);
      ra   = 12'($urandom);
      rb   = 12'($urandom);
      rcin = 1'($urandom);
      rsub = 1'($urandom);
      ref_model(w, ra, rb, rcin, rsub, rs, rc, ro);
      run_op(sel, ra, rb, rcin, rsub, $urandom_range(0, 3), 1'b0, rs, rc, ro, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
